// File: rtl/sipo_8.sv
// UART-style serial-in parallel-out receiver: 8 data bits MSB first, oversampled by OSR,
// with a 3-sample majority vote at each bit centre and stop-bit framing check.
module sipo_8 #(
    parameter int unsigned OSR = 16
) (
    input  logic       clk_baud,
    input  logic       reset_n,
    input  logic       rxd,
    output logic [7:0] data_byte,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int unsigned CntW = $clog2(OSR);
    localparam logic [CntW-1:0] CntHalf = CntW'(OSR / 2 - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(OSR - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      sr_q, sr_d;
    logic [7:0]      data_byte_q, data_byte_d;
    logic            rx_done_q, rx_done_d;
    logic            frame_err_q, frame_err_d;

    logic sync1_q, rxd_s_q, hist1_q, hist2_q;
    logic vote, fall;

    // Synchronizer plus two history taps feeding the majority vote
    always_ff @(posedge clk_baud or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            rxd_s_q <= 1'b1;
            hist1_q <= 1'b1;
            hist2_q <= 1'b1;
        end else begin
            sync1_q <= rxd;
            rxd_s_q <= sync1_q;
            hist1_q <= rxd_s_q;
            hist2_q <= hist1_q;
        end
    end

    assign vote = (rxd_s_q & hist1_q) | (rxd_s_q & hist2_q) | (hist1_q & hist2_q);
    assign fall = ~rxd_s_q & hist1_q;

    always_ff @(posedge clk_baud or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            sr_q        <= '0;
            data_byte_q <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            sr_q        <= sr_d;
            data_byte_q <= data_byte_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        sr_d        = sr_q;
        data_byte_d = data_byte_q;
        rx_done_d   = 1'b0;
        frame_err_d = frame_err_q;
        case (state_q)
            StIdle: begin
                if (fall) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == CntHalf) begin
                    cnt_d = '0;
                    if (vote) begin
                        state_d = StIdle;
                    end else begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (cnt_q == CntFull) begin
                    cnt_d     = '0;
                    sr_d      = {sr_q[6:0], vote};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (cnt_q == CntFull) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (vote) begin
                        data_byte_d = sr_q;
                        rx_done_d   = 1'b1;
                        frame_err_d = 1'b0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign data_byte = data_byte_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = (state_q != StIdle);

endmodule

// File: tb/tb_sipo_8.sv
// Self-checking bench for sipo_8: a frame-level event model predicts busy windows,
// rx_done pulses, data_byte and frame_err cycle by cycle.
module tb_sipo_8;

    localparam int OSR = 16;
    localparam int KGood = 0, KBad = 1, KFalse = 2;

    logic       clk_baud = 1'b0;
    logic       reset_n;
    logic       rxd;
    logic [7:0] data_byte;
    logic       rx_done, frame_err, rx_busy;

    sipo_8 #(.OSR(OSR)) dut (
        .clk_baud (clk_baud),
        .reset_n  (reset_n),
        .rxd      (rxd),
        .data_byte(data_byte),
        .rx_done  (rx_done),
        .frame_err(frame_err),
        .rx_busy  (rx_busy)
    );

    always #5 clk_baud = ~clk_baud;

    typedef struct {
        int         start;
        int         fin;
        logic [7:0] data;
        int         kind;
    } ev_t;

    ev_t        q[$];
    int         cyc = 0;
    int         n_cmp = 0, n_err = 0;
    logic [7:0] m_data = 8'h00;
    logic       m_ferr = 1'b0, e_done = 1'b0, e_busy = 1'b0;
    int         done_count = 0, det_cyc = 0, last_lat = 0;
    logic       busy_prev = 1'b0;

    always @(posedge clk_baud) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: only the head event can be active since frames never overlap in time
    always @(negedge clk_baud) begin
        e_done = 1'b0;
        e_busy = 1'b0;
        if (!reset_n) begin
            q.delete();
            m_data = 8'h00;
            m_ferr = 1'b0;
        end else if (q.size() > 0) begin
            if (cyc >= q[0].start && cyc < q[0].fin) e_busy = 1'b1;
            if (cyc == q[0].fin) begin
                if (q[0].kind == KGood) begin
                    m_data = q[0].data;
                    m_ferr = 1'b0;
                    e_done = 1'b1;
                end else if (q[0].kind == KBad) begin
                    m_ferr = 1'b1;
                end
                void'(q.pop_front());
            end
        end
        chk("rx_busy", {31'd0, rx_busy}, {31'd0, e_busy});
        chk("rx_done", {31'd0, rx_done}, {31'd0, e_done});
        chk("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
        chk("data_byte", {24'd0, data_byte}, {24'd0, m_data});
        if (rx_busy && !busy_prev) det_cyc = cyc;
        if (rx_done) begin
            done_count++;
            last_lat = cyc - det_cyc;
        end
        busy_prev = rx_busy;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_baud);
            #1;
        end
    endtask

    // Bit index 0 = start, 1..8 = b[7]..b[0], 9 = stop. glitch_idx inverts rxd for one
    // cycle at that bit's centre; rst_idx asserts reset at that bit's centre and aborts.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch_idx,
                              input int rst_idx);
        logic [9:0] bits;
        ev_t        e;
        bits    = {1'b0, b, stop};
        e.start = cyc + 3;
        e.fin   = cyc + 3 + OSR / 2 + 9 * OSR;
        e.data  = b;
        e.kind  = stop ? KGood : KBad;
        q.push_back(e);
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < OSR; j++) begin
                if (i == rst_idx && j == OSR / 2) begin
                    reset_n = 1'b0;
                    rxd     = 1'b1;
                    return;
                end
                rxd = bits[9-i] ^ ((i == glitch_idx) && (j == OSR / 2));
                step(1);
            end
        end
        rxd = 1'b1;
    endtask

    initial begin
        ev_t e;
        int  dc;
        reset_n = 1'b0;
        rxd     = 1'b1;
        step(5);
        chk("reset_data", {24'd0, data_byte}, 32'h00);
        reset_n = 1'b1;
        step(10);

        send_frame(8'hA5, 1'b1, -1, -1);
        step(20);
        chk("A5_data", {24'd0, data_byte}, 32'hA5);
        chk("A5_latency", last_lat, 152);
        chk("A5_ferr", {31'd0, frame_err}, 32'd0);

        // 4-cycle low pulse: a false start
        e.start = cyc + 3;
        e.fin   = cyc + 3 + OSR / 2;
        e.data  = 8'h00;
        e.kind  = KFalse;
        q.push_back(e);
        dc  = done_count;
        rxd = 1'b0;
        step(4);
        rxd = 1'b1;
        step(30);
        chk("false_no_done", done_count, dc);
        chk("false_data", {24'd0, data_byte}, 32'hA5);

        send_frame(8'h3C, 1'b0, -1, -1);
        step(20);
        chk("3C_ferr", {31'd0, frame_err}, 32'd1);
        chk("3C_data", {24'd0, data_byte}, 32'hA5);
        send_frame(8'h81, 1'b1, -1, -1);
        step(20);
        chk("81_data", {24'd0, data_byte}, 32'h81);
        chk("81_ferr", {31'd0, frame_err}, 32'd0);

        dc = done_count;
        send_frame(8'h00, 1'b1, -1, -1);
        send_frame(8'hFF, 1'b1, -1, -1);
        step(20);
        chk("b2b_dones", done_count - dc, 2);
        chk("b2b_data", {24'd0, data_byte}, 32'hFF);

        send_frame(8'h55, 1'b1, 4, -1);
        step(20);
        chk("glitch_data", {24'd0, data_byte}, 32'h55);

        dc = done_count;
        send_frame(8'hC3, 1'b1, -1, 5);
        step(5);
        chk("abort_data", {24'd0, data_byte}, 32'h00);
        reset_n = 1'b1;
        step(40);
        chk("abort_no_done", done_count, dc);
        send_frame(8'h96, 1'b1, -1, -1);
        step(20);
        chk("96_data", {24'd0, data_byte}, 32'h96);
        chk("96_dones", done_count - dc, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
